// File: rtl/jzjpcc_pkg.sv
// Shared definitions for the jzjpcc load/store unit: funct3 encodings, access sizing, FSM states.
package jzjpcc_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    StIdle,
    StSecond,
    StWait,
    StResp
  } lsu_state_t;

  // Access size in bytes (1, 2 or 4); unsigned variants share the low funct3 bits.
  function automatic logic [2:0] access_size(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic funct3_legal(input logic write, input logic [2:0] funct3);
    if (write) begin
      return funct3 inside {F3_B, F3_H, F3_W};
    end
    return funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  endfunction

endpackage

// File: rtl/jzjpcc_lsu_if.sv
// Request/response handshake plus word-addressed SRAM port of the load/store unit.
interface jzjpcc_lsu_if #(
  parameter int unsigned ADDR_WIDTH = 14
);

  logic                  reqValid;
  logic                  reqReady;
  logic                  reqWrite;
  logic [2:0]            reqFunct3;
  logic [31:0]           reqAddress;
  logic [31:0]           reqWriteData;
  logic                  rspValid;
  logic                  rspReady;
  logic [31:0]           rspData;
  logic                  rspError;
  logic [ADDR_WIDTH-1:0] sramAddress;
  logic                  sramWriteEnable;
  logic [3:0]            sramByteWriteMask;
  logic [31:0]           sramWriteData;
  logic [31:0]           sramReadData;

  // Environment side: memory stage plus the data RAM.
  modport master (
    output reqValid, reqWrite, reqFunct3, reqAddress, reqWriteData, rspReady, sramReadData,
    input  reqReady, rspValid, rspData, rspError,
    input  sramAddress, sramWriteEnable, sramByteWriteMask, sramWriteData
  );

  // The LSU itself.
  modport slave (
    input  reqValid, reqWrite, reqFunct3, reqAddress, reqWriteData, rspReady, sramReadData,
    output reqReady, rspValid, rspData, rspError,
    output sramAddress, sramWriteEnable, sramByteWriteMask, sramWriteData
  );

endinterface

// File: rtl/jzjpcc_load_aligner.sv
// Extracts the addressed bytes from a (high, low) word pair and sign/zero-extends them.
module jzjpcc_load_aligner
  import jzjpcc_pkg::*;
(
  input  logic [31:0] low_word,
  input  logic [31:0] high_word,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [31:0] window;

  assign window = 32'({high_word, low_word} >> {offset, 3'b000});

  always_comb begin
    result = window;
    case (funct3)
      F3_B:    result = {{24{window[7]}}, window[7:0]};
      F3_H:    result = {{16{window[15]}}, window[15:0]};
      F3_BU:   result = {24'b0, window[7:0]};
      F3_HU:   result = {16'b0, window[15:0]};
      default: result = window;
    endcase
  end

endmodule

// File: rtl/jzjpcc_lsu.sv
// RV32I load/store unit driving a synchronous-read, byte-masked word SRAM port.
module jzjpcc_lsu
  import jzjpcc_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH       = 14,
  parameter bit          MISALIGNED_SPLIT = 1'b1
) (
  input logic          clock,
  input logic          not_reset,
  jzjpcc_lsu_if.slave  bus
);

  lsu_state_t            state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [2:0]            funct3_q;
  logic [1:0]            off_q;
  logic                  write_q;
  logic                  crossing_q;
  logic [3:0]            hi_mask_q;
  logic [31:0]           hi_data_q;
  logic [31:0]           low_word_q;
  logic                  rsp_valid_q;
  logic                  rsp_error_q;
  logic [31:0]           rsp_data_q;

  logic                  ready;
  logic                  accept;
  logic [1:0]            off;
  logic [3:0]            base_mask;
  logic [7:0]            req_mask;
  logic [63:0]           req_data;
  logic                  crossing;
  logic                  req_error;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic [31:0]           align_low;
  logic [31:0]           align_high;
  logic [31:0]           aligned;
  logic                  unused_addr;

  assign off         = bus.reqAddress[1:0];
  assign word_addr   = bus.reqAddress[ADDR_WIDTH+1:2];
  assign unused_addr = ^bus.reqAddress[31:ADDR_WIDTH+2];
  assign base_mask   = 4'((5'd1 << access_size(bus.reqFunct3)) - 5'd1);
  assign req_mask    = {4'b0000, base_mask} << off;
  assign req_data    = {32'b0, bus.reqWriteData} << {off, 3'b000};
  assign crossing    = |req_mask[7:4];
  assign req_error   = !funct3_legal(bus.reqWrite, bus.reqFunct3) ||
                       (crossing && !MISALIGNED_SPLIT);

  // Gated by reset so every output reads 0 while not_reset is low.
  assign ready  = not_reset && (state_q == StIdle);
  assign accept = ready && bus.reqValid;

  assign bus.reqReady = ready;
  assign bus.rspValid = rsp_valid_q;
  assign bus.rspError = rsp_error_q;
  assign bus.rspData  = rsp_data_q;

  // First access comes straight from the request; the second from latched state.
  always_comb begin
    bus.sramAddress       = '0;
    bus.sramWriteEnable   = 1'b0;
    bus.sramByteWriteMask = 4'b0000;
    bus.sramWriteData     = '0;
    if (not_reset) begin
      case (state_q)
        StIdle: begin
          if (accept && !req_error) begin
            bus.sramAddress = word_addr;
            if (bus.reqWrite) begin
              bus.sramWriteEnable   = 1'b1;
              bus.sramByteWriteMask = req_mask[3:0];
              bus.sramWriteData     = req_data[31:0];
            end
          end
        end
        StSecond: begin
          bus.sramAddress = addr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
          if (write_q) begin
            bus.sramWriteEnable   = 1'b1;
            bus.sramByteWriteMask = hi_mask_q;
            bus.sramWriteData     = hi_data_q;
          end
        end
        default: ;
      endcase
    end
  end

  // In StWait the read data is the high word for a crossing load, else the only word.
  assign align_low  = crossing_q ? low_word_q : bus.sramReadData;
  assign align_high = crossing_q ? bus.sramReadData : '0;

  jzjpcc_load_aligner u_load_aligner (
    .low_word  (align_low),
    .high_word (align_high),
    .offset    (off_q),
    .funct3    (funct3_q),
    .result    (aligned)
  );

  always_ff @(posedge clock or negedge not_reset) begin
    if (!not_reset) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      funct3_q    <= 3'b000;
      off_q       <= 2'b00;
      write_q     <= 1'b0;
      crossing_q  <= 1'b0;
      hi_mask_q   <= 4'b0000;
      hi_data_q   <= '0;
      low_word_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            addr_q     <= word_addr;
            funct3_q   <= bus.reqFunct3;
            off_q      <= off;
            write_q    <= bus.reqWrite;
            crossing_q <= crossing;
            hi_mask_q  <= req_mask[7:4];
            hi_data_q  <= req_data[63:32];
            if (req_error) begin
              rsp_valid_q <= 1'b1;
              rsp_error_q <= 1'b1;
              rsp_data_q  <= '0;
              state_q     <= StResp;
            end else if (crossing) begin
              state_q <= StSecond;
            end else if (bus.reqWrite) begin
              rsp_valid_q <= 1'b1;
              state_q     <= StResp;
            end else begin
              state_q <= StWait;
            end
          end
        end
        StSecond: begin
          if (write_q) begin
            rsp_valid_q <= 1'b1;
            state_q     <= StResp;
          end else begin
            low_word_q <= bus.sramReadData;
            state_q    <= StWait;
          end
        end
        StWait: begin
          rsp_valid_q <= 1'b1;
          rsp_data_q  <= aligned;
          state_q     <= StResp;
        end
        StResp: begin
          if (bus.rspReady) begin
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_data_q  <= '0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_jzjpcc_lsu.sv
// Directed bench for jzjpcc_lsu with a behavioural byte-masked synchronous SRAM.
module tb_jzjpcc_lsu;

  logic clock;
  logic not_reset;
  int   checks;
  int   errors;

  jzjpcc_lsu_if #(.ADDR_WIDTH(14)) bus ();
  jzjpcc_lsu_if #(.ADDR_WIDTH(14)) bus2 ();

  jzjpcc_lsu #(.ADDR_WIDTH(14), .MISALIGNED_SPLIT(1'b1)) dut (
    .clock     (clock),
    .not_reset (not_reset),
    .bus       (bus)
  );

  jzjpcc_lsu #(.ADDR_WIDTH(14), .MISALIGNED_SPLIT(1'b0)) dut_nosplit (
    .clock     (clock),
    .not_reset (not_reset),
    .bus       (bus2)
  );

  logic [31:0] mem [0:16383];

  always @(posedge clock) begin
    if (bus.sramWriteEnable) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.sramByteWriteMask[b]) begin
          mem[bus.sramAddress][8*b +: 8] <= bus.sramWriteData[8*b +: 8];
        end
      end
    end
    bus.sramReadData <= mem[bus.sramAddress];
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic start_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] d);
    @(negedge clock);
    bus.reqValid     = 1'b1;
    bus.reqWrite     = w;
    bus.reqFunct3    = f3;
    bus.reqAddress   = a;
    bus.reqWriteData = d;
    #1;
  endtask

  task automatic step;
    @(negedge clock);
    bus.reqValid  = 1'b0;
    bus2.reqValid = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    not_reset = 1'b0;
    #1;
    checks++;
    if (bus.reqReady !== 1'b0 || bus.rspValid !== 1'b0 || bus.sramWriteEnable !== 1'b0 ||
        bus.sramByteWriteMask !== 4'h0 || bus.sramAddress !== 14'h0) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%b rv=%b we=%b mask=%h addr=%h want all 0",
               bus.reqReady, bus.rspValid, bus.sramWriteEnable, bus.sramByteWriteMask,
               bus.sramAddress);
    end
    @(negedge clock);
    @(negedge clock);
    not_reset = 1'b1;
    #1;
    checks++;
    if (bus.reqReady !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b want 1", bus.reqReady);
    end
  endtask

  task automatic test_store_word;
    start_req(1'b1, 3'b010, 32'h0000_1000, 32'hDEAD_BEEF);
    checks++;
    if (bus.sramAddress !== 14'h400 || bus.sramByteWriteMask !== 4'hF ||
        bus.sramWriteEnable !== 1'b1 || bus.sramWriteData !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL sw_cycle0: addr=%h mask=%h we=%b wd=%h want 400 f 1 deadbeef",
               bus.sramAddress, bus.sramByteWriteMask, bus.sramWriteEnable, bus.sramWriteData);
    end
    step();
    checks++;
    if (bus.rspValid !== 1'b1 || bus.rspError !== 1'b0 || bus.rspData !== 32'h0 ||
        bus.reqReady !== 1'b0) begin
      errors++;
      $display("FAIL sw_resp: rv=%b err=%b data=%h rdy=%b want 1 0 0 0",
               bus.rspValid, bus.rspError, bus.rspData, bus.reqReady);
    end
    step();
    checks++;
    if (bus.reqReady !== 1'b1 || bus.rspValid !== 1'b0) begin
      errors++;
      $display("FAIL sw_idle: rdy=%b rv=%b want 1 0", bus.reqReady, bus.rspValid);
    end
  endtask

  task automatic test_load_extend;
    logic [2:0]  f3s  [3] = '{3'b000, 3'b100, 3'b001};
    logic [31:0] adrs [3] = '{32'h1003, 32'h1003, 32'h1002};
    logic [31:0] exps [3] = '{32'hFFFF_FFDE, 32'h0000_00DE, 32'hFFFF_DEAD};
    for (int i = 0; i < 3; i++) begin
      start_req(1'b0, f3s[i], adrs[i], 32'h0);
      checks++;
      if (bus.sramAddress !== 14'h400 || bus.sramWriteEnable !== 1'b0) begin
        errors++;
        $display("FAIL load%0d_cycle0: addr=%h we=%b want 400 0",
                 i, bus.sramAddress, bus.sramWriteEnable);
      end
      step();
      checks++;
      if (bus.rspValid !== 1'b0) begin
        errors++;
        $display("FAIL load%0d_wait: rv=%b want 0", i, bus.rspValid);
      end
      step();
      checks++;
      if (bus.rspValid !== 1'b1 || bus.rspData !== exps[i] || bus.rspError !== 1'b0) begin
        errors++;
        $display("FAIL load%0d_data: rv=%b data=%h err=%b want 1 %h 0",
                 i, bus.rspValid, bus.rspData, bus.rspError, exps[i]);
      end
      step();
    end
  endtask

  task automatic test_split_half;
    start_req(1'b1, 3'b001, 32'h0000_1003, 32'h0000_ABCD);
    checks++;
    if (bus.sramAddress !== 14'h400 || bus.sramByteWriteMask !== 4'b1000 ||
        bus.sramWriteEnable !== 1'b1 || bus.sramWriteData[31:24] !== 8'hCD) begin
      errors++;
      $display("FAIL sh_split_c0: addr=%h mask=%b we=%b b3=%h want 400 1000 1 cd",
               bus.sramAddress, bus.sramByteWriteMask, bus.sramWriteEnable,
               bus.sramWriteData[31:24]);
    end
    step();
    checks++;
    if (bus.sramAddress !== 14'h401 || bus.sramByteWriteMask !== 4'b0001 ||
        bus.sramWriteEnable !== 1'b1 || bus.sramWriteData[7:0] !== 8'hAB ||
        bus.rspValid !== 1'b0) begin
      errors++;
      $display("FAIL sh_split_c1: addr=%h mask=%b we=%b b0=%h rv=%b want 401 0001 1 ab 0",
               bus.sramAddress, bus.sramByteWriteMask, bus.sramWriteEnable,
               bus.sramWriteData[7:0], bus.rspValid);
    end
    step();
    checks++;
    if (bus.rspValid !== 1'b1 || bus.rspError !== 1'b0) begin
      errors++;
      $display("FAIL sh_split_resp: rv=%b err=%b want 1 0", bus.rspValid, bus.rspError);
    end
    step();
    start_req(1'b0, 3'b101, 32'h0000_1003, 32'h0);
    step();
    step();
    checks++;
    if (bus.rspValid !== 1'b0) begin
      errors++;
      $display("FAIL lhu_split_c2: rv=%b want 0", bus.rspValid);
    end
    step();
    checks++;
    if (bus.rspValid !== 1'b1 || bus.rspData !== 32'h0000_ABCD) begin
      errors++;
      $display("FAIL lhu_split_data: rv=%b data=%h want 1 0000abcd", bus.rspValid, bus.rspData);
    end
    step();
  endtask

  task automatic test_wrap_backpressure;
    logic [31:0] held;
    start_req(1'b1, 3'b010, 32'h0000_FFFC, 32'h1122_3344);
    step();
    step();
    start_req(1'b1, 3'b010, 32'h0000_0000, 32'h5566_7788);
    step();
    step();
    bus.rspReady = 1'b0;
    start_req(1'b0, 3'b010, 32'h0000_FFFE, 32'h0);
    checks++;
    if (bus.sramAddress !== 14'h3FFF || bus.sramWriteEnable !== 1'b0) begin
      errors++;
      $display("FAIL lw_wrap_c0: addr=%h we=%b want 3fff 0", bus.sramAddress, bus.sramWriteEnable);
    end
    step();
    checks++;
    if (bus.sramAddress !== 14'h0000 || bus.sramWriteEnable !== 1'b0 ||
        bus.sramByteWriteMask !== 4'h0) begin
      errors++;
      $display("FAIL lw_wrap_c1: addr=%h we=%b mask=%h want 0 0 0",
               bus.sramAddress, bus.sramWriteEnable, bus.sramByteWriteMask);
    end
    step();
    step();
    checks++;
    if (bus.rspValid !== 1'b1 || bus.rspData !== 32'h7788_1122) begin
      errors++;
      $display("FAIL lw_wrap_data: rv=%b data=%h want 1 77881122", bus.rspValid, bus.rspData);
    end
    held = 32'h7788_1122;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (bus.rspValid !== 1'b1 || bus.rspData !== held || bus.reqReady !== 1'b0 ||
          bus.sramWriteEnable !== 1'b0 || bus.sramByteWriteMask !== 4'h0) begin
        errors++;
        $display("FAIL hold%0d: rv=%b data=%h rdy=%b we=%b mask=%h want 1 %h 0 0 0", i,
                 bus.rspValid, bus.rspData, bus.reqReady, bus.sramWriteEnable,
                 bus.sramByteWriteMask, held);
      end
    end
    bus.rspReady = 1'b1;
    step();
    checks++;
    if (bus.rspValid !== 1'b0 || bus.reqReady !== 1'b1) begin
      errors++;
      $display("FAIL hold_release: rv=%b rdy=%b want 0 1", bus.rspValid, bus.reqReady);
    end
  endtask

  task automatic test_errors;
    start_req(1'b0, 3'b011, 32'h0000_1000, 32'h0);
    checks++;
    if (bus.sramWriteEnable !== 1'b0 || bus.sramAddress !== 14'h0 ||
        bus.sramByteWriteMask !== 4'h0) begin
      errors++;
      $display("FAIL bad_load_c0: we=%b addr=%h mask=%h want 0 0 0",
               bus.sramWriteEnable, bus.sramAddress, bus.sramByteWriteMask);
    end
    step();
    checks++;
    if (bus.rspValid !== 1'b1 || bus.rspError !== 1'b1 || bus.rspData !== 32'h0) begin
      errors++;
      $display("FAIL bad_load_resp: rv=%b err=%b data=%h want 1 1 0",
               bus.rspValid, bus.rspError, bus.rspData);
    end
    step();
    start_req(1'b1, 3'b011, 32'h0000_1000, 32'hFFFF_FFFF);
    checks++;
    if (bus.sramWriteEnable !== 1'b0) begin
      errors++;
      $display("FAIL bad_store_we: got %b want 0", bus.sramWriteEnable);
    end
    step();
    checks++;
    if (bus.rspError !== 1'b1 || mem[14'h400] !== 32'hCDAD_BEEF) begin
      errors++;
      $display("FAIL bad_store_resp: err=%b mem400=%h want 1 cdadbeef",
               bus.rspError, mem[14'h400]);
    end
    step();
    // MISALIGNED_SPLIT=0 instance: crossing LW is an error, aligned LW is not.
    @(negedge clock);
    bus2.reqValid = 1'b1; bus2.reqWrite = 1'b0; bus2.reqFunct3 = 3'b010;
    bus2.reqAddress = 32'h0000_1001; bus2.reqWriteData = 32'h0;
    #1;
    checks++;
    if (bus2.sramWriteEnable !== 1'b0 || bus2.sramAddress !== 14'h0) begin
      errors++;
      $display("FAIL nosplit_c0: we=%b addr=%h want 0 0", bus2.sramWriteEnable, bus2.sramAddress);
    end
    step();
    checks++;
    if (bus2.rspValid !== 1'b1 || bus2.rspError !== 1'b1 || bus2.rspData !== 32'h0) begin
      errors++;
      $display("FAIL nosplit_resp: rv=%b err=%b data=%h want 1 1 0",
               bus2.rspValid, bus2.rspError, bus2.rspData);
    end
    step();
    @(negedge clock);
    bus2.reqValid = 1'b1; bus2.reqAddress = 32'h0000_1000;
    #1;
    checks++;
    if (bus2.sramAddress !== 14'h400) begin
      errors++;
      $display("FAIL nosplit_aligned_addr: got %h want 400", bus2.sramAddress);
    end
    step();
    step();
    checks++;
    if (bus2.rspValid !== 1'b1 || bus2.rspError !== 1'b0) begin
      errors++;
      $display("FAIL nosplit_aligned_resp: rv=%b err=%b want 1 0", bus2.rspValid, bus2.rspError);
    end
    step();
  endtask

  task automatic test_reset_mid_split;
    start_req(1'b1, 3'b010, 32'h0000_1004, 32'h0123_4567);
    step();
    step();
    start_req(1'b1, 3'b010, 32'h0000_1002, 32'hCAFE_F00D);
    checks++;
    if (bus.sramByteWriteMask !== 4'b1100 || bus.sramWriteEnable !== 1'b1 ||
        bus.sramWriteData !== 32'hF00D_0000) begin
      errors++;
      $display("FAIL sw_split_c0: mask=%b we=%b wd=%h want 1100 1 f00d0000",
               bus.sramByteWriteMask, bus.sramWriteEnable, bus.sramWriteData);
    end
    step();
    not_reset = 1'b0;
    #1;
    checks++;
    if (bus.sramWriteEnable !== 1'b0 || bus.sramByteWriteMask !== 4'h0 ||
        bus.sramAddress !== 14'h0 || bus.sramWriteData !== 32'h0 ||
        bus.reqReady !== 1'b0 || bus.rspValid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_outputs: we=%b mask=%h addr=%h wd=%h rdy=%b rv=%b want all 0",
               bus.sramWriteEnable, bus.sramByteWriteMask, bus.sramAddress,
               bus.sramWriteData, bus.reqReady, bus.rspValid);
    end
    @(negedge clock);
    not_reset = 1'b1;
    #1;
    checks++;
    if (bus.reqReady !== 1'b1) begin
      errors++;
      $display("FAIL midreset_ready: got %b want 1", bus.reqReady);
    end
    checks++;
    if (mem[14'h401] !== 32'h0123_4567 || mem[14'h400] !== 32'hF00D_BEEF) begin
      errors++;
      $display("FAIL midreset_mem: w401=%h w400=%h want 01234567 f00dbeef",
               mem[14'h401], mem[14'h400]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    errors = 0;
    bus.reqValid = 1'b0; bus.reqWrite = 1'b0; bus.reqFunct3 = 3'b000;
    bus.reqAddress = 32'h0; bus.reqWriteData = 32'h0; bus.rspReady = 1'b1;
    bus2.reqValid = 1'b0; bus2.reqWrite = 1'b0; bus2.reqFunct3 = 3'b000;
    bus2.reqAddress = 32'h0; bus2.reqWriteData = 32'h0; bus2.rspReady = 1'b1;
    bus2.sramReadData = 32'h0;
    test_reset();
    test_store_word();
    test_load_extend();
    test_split_half();
    test_wrap_backpressure();
    test_errors();
    test_reset_mid_split();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
